// File: rtl/staff_pkg.sv
// staff_pkg: shared widths, the rest marker and the scheduler state type
// for the staff-cell scheduling slice.
package staff_pkg;

    localparam int NUM_VOICES = 5;
    localparam int CELL_W     = 6;
    localparam int VOICE_W    = 3;
    localparam int ENTRY_W    = 12;

    localparam logic [7:0]         REST_NOTE  = 8'hFF;
    localparam logic [ENTRY_W-1:0] REST_ENTRY = {4'h0, REST_NOTE};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sched_state_t;

    // Lowest-numbered voice still waiting in the mask (0 when the mask is empty).
    function automatic logic [VOICE_W-1:0] first_voice(input logic [NUM_VOICES-1:0] mask);
        logic [VOICE_W-1:0] idx;
        idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (mask[v]) idx = VOICE_W'(v);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sixteenth_metronome.sv
// sixteenth_metronome: phase accumulator that emits one tick per sixteenth
// note. Each enabled cycle adds 4*bpm; crossing TICKS_PER_MIN wraps and ticks.
module sixteenth_metronome #(
    parameter int unsigned TICKS_PER_MIN = 1_500_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] bpm,
    output logic       tick
);

    localparam logic [32:0] LIMIT = 33'(TICKS_PER_MIN);

    logic [31:0] acc_q;
    logic [32:0] sum;

    // Candidate phase for this cycle; the tick is combinational so it lines
    // up with the edge that consumes it.
    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    always_comb begin
        sum  = {1'b0, acc_q} + {23'd0, bpm, 2'b00};
        tick = enable && (sum >= LIMIT);
    end

    // Phase register: cleared on playback start, advanced only while enabled.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= tick ? 32'(sum - LIMIT) : sum[31:0];
        end
    end

endmodule

// File: rtl/staff_cell_scheduler.sv
// staff_cell_scheduler: walks the staff cells at the current tempo, snapshots
// the detected notes on every cell advance and flushes the non-rest voices of
// that snapshot to staff memory over a valid/ready write port.
module staff_cell_scheduler
    import staff_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN = 1_500_000_000,
    parameter int unsigned NUM_CELLS     = 48
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic [7:0]  bpm_in,
    input  logic [59:0] detected_note_in,
    output logic [5:0]  current_staff_cell_out,
    output logic        cell_tick_out,
    output logic        wr_valid_out,
    input  logic        wr_ready_in,
    output logic [8:0]  wr_addr_out,
    output logic [11:0] wr_data_out,
    output logic        busy_out,
    output logic        overrun_out
);

    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_CELLS - 1);

    sched_state_t          state_q, state_d;
    logic                  tick, run_en, start_run, flush_pending;
    logic [NUM_VOICES-1:0] pend_q, new_mask;
    logic [ENTRY_W-1:0]    snap_q [NUM_VOICES];
    logic [CELL_W-1:0]     snap_cell_q;
    logic [VOICE_W-1:0]    next_voice;

    assign run_en        = (state_q == RUN);
    assign busy_out      = (state_q != IDLE);
    assign cell_tick_out = tick;

    sixteenth_metronome #(
        .TICKS_PER_MIN(TICKS_PER_MIN)
    ) u_metronome (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .enable  (run_en),
        .clear   (start_run),
        .bpm     (bpm_in),
        .tick    (tick)
    );

    // Next-state decode; leaving DRAIN waits for the last write to be accepted.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (stop_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (pend_q == '0 && (!wr_valid_out || wr_ready_in)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush qualifiers: which voices of the incoming notes are real, and
    // whether the current snapshot still has unwritten work.
    always_comb begin
        new_mask = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            new_mask[v] = (detected_note_in[v*ENTRY_W +: 8] != REST_NOTE);
        end
        flush_pending = (pend_q != '0) || (wr_valid_out && !wr_ready_in);
        next_voice    = first_voice(pend_q);
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Cell position: restarts at 0 on playback start, wraps at the page end.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            current_staff_cell_out <= '0;
        end else if (start_run) begin
            current_staff_cell_out <= '0;
        end else if (tick) begin
            current_staff_cell_out <= (current_staff_cell_out == LAST_CELL) ?
                                      '0 : current_staff_cell_out + 1'b1;
        end
    end

    // Snapshot of the voices for the cell being left, tagged with that cell.
    // NOTE: the snapshot is a few flops, so it takes the reset like any register; a RAM would not.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int v = 0; v < NUM_VOICES; v++) snap_q[v] <= REST_ENTRY;
            snap_cell_q <= '0;
        end else if (tick) begin
            for (int v = 0; v < NUM_VOICES; v++) snap_q[v] <= detected_note_in[v*ENTRY_W +: ENTRY_W];
            snap_cell_q <= current_staff_cell_out;
        end
    end

    // Write port: a tick abandons any unfinished flush and arms the new
    // snapshot; otherwise present one pending voice at a time and hold it
    // until accepted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_q       <= '0;
            wr_valid_out <= 1'b0;
            wr_addr_out  <= '0;
            wr_data_out  <= REST_ENTRY;
        end else if (tick) begin
            pend_q       <= new_mask;
            wr_valid_out <= 1'b0;
        end else if (wr_valid_out && wr_ready_in) begin
            wr_valid_out <= 1'b0;
        end else if (!wr_valid_out && pend_q != '0) begin
            wr_valid_out       <= 1'b1;
            wr_addr_out        <= {snap_cell_q, next_voice};
            wr_data_out        <= snap_q[next_voice];
            pend_q[next_voice] <= 1'b0;
        end
    end

    // Sticky overrun flag, cleared only when playback starts again.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_out <= 1'b0;
        end else if (start_run) begin
            overrun_out <= 1'b0;
        end else if (tick && flush_pending) begin
            overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_staff_cell_scheduler.sv
// tb_staff_cell_scheduler: randomized and directed scenarios checked against
// a cumulative-tempo reference model of cell ticks and expected memory writes.
module tb_staff_cell_scheduler;

    localparam int T     = 4800;
    localparam int CELLS = 48;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;
    logic        wr_ready_in = 1'b0;
    logic [7:0]  bpm_in = 8'd120;
    logic [59:0] detected_note_in = {5{12'h0FF}};
    logic [5:0]  current_staff_cell_out;
    logic        cell_tick_out;
    logic        wr_valid_out;
    logic [8:0]  wr_addr_out;
    logic [11:0] wr_data_out;
    logic        busy_out;
    logic        overrun_out;

    int passed = 0;
    int total  = 0;

    staff_cell_scheduler #(
        .TICKS_PER_MIN(T),
        .NUM_CELLS    (CELLS)
    ) dut (
        .clk_in                (clk_in),
        .rst_n_in              (rst_n_in),
        .start_in              (start_in),
        .stop_in               (stop_in),
        .bpm_in                (bpm_in),
        .detected_note_in      (detected_note_in),
        .current_staff_cell_out(current_staff_cell_out),
        .cell_tick_out         (cell_tick_out),
        .wr_valid_out          (wr_valid_out),
        .wr_ready_in           (wr_ready_in),
        .wr_addr_out           (wr_addr_out),
        .wr_data_out           (wr_data_out),
        .busy_out              (busy_out),
        .overrun_out           (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Reference model: total tempo credit since start; the k-th tick is due
    // in the first cycle where credit reaches k*T.
    bit          mon_en = 1'b0;
    bit          model_run = 1'b0;
    bit          exp_tick;
    longint      model_total = 0;
    int          model_ticks = 0;
    int          start_cyc = 0;
    int          obs_ticks = 0;
    int          last_wr_cyc = 0;
    int          tick_cyc[$];
    int          obs_cell[$];
    logic [20:0] exp_wr[$];
    logic [20:0] obs_wr[$];
    bit          prev_hold = 1'b0;
    bit          prev_tick = 1'b0;
    logic [8:0]  prev_addr;
    logic [11:0] prev_data;

    always @(negedge clk_in) begin
        if (!rst_n_in || !mon_en) begin
            prev_hold = 1'b0;
            prev_tick = 1'b0;
            if (!rst_n_in) model_run = 1'b0;
        end else begin
            exp_tick = 1'b0;
            if (model_run) begin
                model_total += longint'(4 * int'(bpm_in));
                exp_tick = (model_total >= longint'(model_ticks + 1) * longint'(T));
            end
            total++;
            if (cell_tick_out !== exp_tick)
                $display("FAIL tick @cyc %0d: cell_tick_out=%b expected %b", cyc, cell_tick_out, exp_tick);
            else passed++;
            if (cell_tick_out === 1'b1) begin
                obs_ticks++;
                tick_cyc.push_back(cyc);
                obs_cell.push_back(int'(current_staff_cell_out));
            end
            if (exp_tick) begin
                total++;
                if (current_staff_cell_out !== 6'(model_ticks % CELLS))
                    $display("FAIL cell @cyc %0d: got %0d expected %0d", cyc, current_staff_cell_out, model_ticks % CELLS);
                else passed++;
                for (int v = 0; v < 5; v++) begin
                    if (detected_note_in[v*12 +: 8] != 8'hFF)
                        exp_wr.push_back({6'(model_ticks % CELLS), 3'(v), detected_note_in[v*12 +: 12]});
                end
                model_ticks++;
            end
            if (prev_hold && !prev_tick) begin
                total++;
                if (wr_valid_out !== 1'b1 || wr_addr_out !== prev_addr || wr_data_out !== prev_data)
                    $display("FAIL hold @cyc %0d: valid=%b addr=%h data=%h expected held addr=%h data=%h",
                             cyc, wr_valid_out, wr_addr_out, wr_data_out, prev_addr, prev_data);
                else passed++;
            end
            prev_hold = wr_valid_out && !wr_ready_in;
            prev_addr = wr_addr_out;
            prev_data = wr_data_out;
            prev_tick = cell_tick_out;
            if (wr_valid_out && wr_ready_in) begin
                obs_wr.push_back({wr_addr_out, wr_data_out});
                last_wr_cyc = cyc;
            end
            if (start_in && !model_run) begin
                model_run   = 1'b1;
                model_total = 0;
                model_ticks = 0;
                start_cyc   = cyc;
            end else if (stop_in && model_run) begin
                model_run = 1'b0;
            end
        end
    end

    task automatic cyc1();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_logs();
        exp_wr.delete();
        obs_wr.delete();
        tick_cyc.delete();
        obs_cell.delete();
        obs_ticks = 0;
    endtask

    task automatic start_pulse();
        start_in = 1'b1;
        cyc1();
        start_in = 1'b0;
    endtask

    task automatic wait_ticks(input int n, input int budget);
        int i;
        i = 0;
        while (obs_ticks < n && i < budget) begin
            cyc1();
            i++;
        end
        total++;
        if (obs_ticks < n) $display("FAIL wait_ticks: saw %0d ticks, wanted %0d", obs_ticks, n);
        else passed++;
    endtask

    task automatic stop_and_drain();
        int i;
        wr_ready_in = 1'b1;
        stop_in = 1'b1;
        cyc1();
        stop_in = 1'b0;
        i = 0;
        while (busy_out !== 1'b0 && i < 200) begin
            cyc1();
            i++;
        end
        total++;
        if (busy_out !== 1'b0) $display("FAIL drain: busy_out=%b after 200 cycles, expected 0", busy_out);
        else passed++;
    endtask

    task automatic compare_writes(input string name);
        total++;
        if (obs_wr.size() != exp_wr.size())
            $display("FAIL %s_count: got %0d writes expected %0d", name, obs_wr.size(), exp_wr.size());
        else passed++;
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
            total++;
            if (obs_wr[i] !== exp_wr[i])
                $display("FAIL %s[%0d]: got %h expected %h", name, i, obs_wr[i], exp_wr[i]);
            else passed++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (current_staff_cell_out !== 6'd0 || cell_tick_out !== 1'b0 || wr_valid_out !== 1'b0 ||
            wr_addr_out !== 9'd0 || wr_data_out !== 12'h0FF || busy_out !== 1'b0 || overrun_out !== 1'b0)
            $display("FAIL %s: cell=%0d tick=%b valid=%b addr=%h data=%h busy=%b ovr=%b expected 0,0,0,000,0ff,0,0",
                     name, current_staff_cell_out, cell_tick_out, wr_valid_out, wr_addr_out, wr_data_out,
                     busy_out, overrun_out);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) cyc1();
        check_reset_outputs("reset_values");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cyc1();
        mon_en = 1'b1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_tempo();
        int bad;
        clear_logs();
        bpm_in = 8'd120;
        detected_note_in = {5{12'h0FF}};
        wr_ready_in = 1'b1;
        start_pulse();
        wait_ticks(20, 300);
        start_pulse();                      // ignored while running
        wait_ticks(50, 400);
        stop_and_drain();
        stop_in = 1'b1;                     // ignored while idle
        cyc1();
        stop_in = 1'b0;
        cyc1();
        total++;
        if (busy_out !== 1'b0) $display("FAIL stop_in_idle: busy_out=%b expected 0", busy_out);
        else passed++;
        total++;
        if (tick_cyc.size() < 50) $display("FAIL tempo_ticks: got %0d ticks expected >=50", tick_cyc.size());
        else begin
            passed++;
            total++;
            if (tick_cyc[0] - start_cyc != 10)
                $display("FAIL first_tick: latency %0d expected 10", tick_cyc[0] - start_cyc);
            else passed++;
            bad = 0;
            for (int k = 1; k < 50; k++) if (tick_cyc[k] - tick_cyc[k-1] != 10) bad++;
            total++;
            if (bad != 0) $display("FAIL tick_period: %0d intervals differ from expected 10", bad);
            else passed++;
            total++;
            if (obs_cell[47] != 47 || obs_cell[48] != 0)
                $display("FAIL cell_wrap: got %0d->%0d expected 47->0", obs_cell[47], obs_cell[48]);
            else passed++;
        end
        total++;
        if (obs_wr.size() != 0) $display("FAIL rest_only_writes: got %0d writes expected 0", obs_wr.size());
        else passed++;
    endtask

    task automatic test_two_writes();
        clear_logs();
        bpm_in = 8'd120;
        wr_ready_in = 1'b1;
        detected_note_in = {5{12'h0FF}};
        start_pulse();
        repeat (54) cyc1();
        detected_note_in = {12'h0FF, 12'h0FF, 12'h240, 12'h0FF, 12'h13C};
        repeat (10) cyc1();
        detected_note_in = {5{12'h0FF}};
        wait_ticks(8, 100);
        stop_and_drain();
        total++;
        if (obs_wr.size() != 2) $display("FAIL cell5_count: got %0d writes expected 2", obs_wr.size());
        else begin
            passed++;
            total++;
            if (obs_wr[0] !== {9'd40, 12'h13C}) $display("FAIL cell5_w0: got %h expected %h", obs_wr[0], {9'd40, 12'h13C});
            else passed++;
            total++;
            if (obs_wr[1] !== {9'd42, 12'h240}) $display("FAIL cell5_w1: got %h expected %h", obs_wr[1], {9'd42, 12'h240});
            else passed++;
        end
    endtask

    task automatic test_random();
        int stall;
        logic [11:0] e;
        clear_logs();
        bpm_in = 8'($urandom_range(20, 40));
        wr_ready_in = 1'b1;
        start_pulse();
        stall = 0;
        for (int c = 0; c < 2000 && obs_ticks < 20; c++) begin
            for (int v = 0; v < 5; v++) begin
                e[11:8] = 4'($urandom_range(0, 15));
                e[7:0]  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                detected_note_in[v*12 +: 12] = e;
            end
            if (stall >= 3) wr_ready_in = 1'b1;
            else            wr_ready_in = 1'($urandom_range(0, 1));
            stall = wr_ready_in ? 0 : stall + 1;
            if (c == 200) bpm_in = 8'($urandom_range(20, 40));
            cyc1();
        end
        detected_note_in = {5{12'h0FF}};
        total++;
        if (obs_ticks < 20) $display("FAIL rand_ticks: saw %0d ticks expected 20", obs_ticks);
        else passed++;
        stop_and_drain();
        compare_writes("rand_wr");
        total++;
        if (overrun_out !== 1'b0) $display("FAIL rand_overrun: got %b expected 0", overrun_out);
        else passed++;
    endtask

    task automatic test_overrun();
        clear_logs();
        bpm_in = 8'd120;
        wr_ready_in = 1'b0;
        detected_note_in = {12'h0FF, 12'h303, 12'h0FF, 12'h202, 12'h101};
        start_pulse();
        repeat (14) cyc1();
        detected_note_in = {12'h5BB, 12'h0FF, 12'h4AA, 12'h0FF, 12'h0FF};
        repeat (4) cyc1();
        total++;
        if (overrun_out !== 1'b0 || wr_valid_out !== 1'b1 || wr_addr_out !== 9'd0 || wr_data_out !== 12'h101)
            $display("FAIL pre_overrun: ovr=%b valid=%b addr=%h data=%h expected 0,1,000,101",
                     overrun_out, wr_valid_out, wr_addr_out, wr_data_out);
        else passed++;
        repeat (2) cyc1();
        total++;
        if (overrun_out !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun_out);
        else passed++;
        repeat (4) cyc1();
        detected_note_in = {5{12'h0FF}};
        cyc1();
        wr_ready_in = 1'b1;
        wait_ticks(4, 60);
        stop_and_drain();
        total++;
        if (obs_wr.size() != 2) $display("FAIL overrun_count: got %0d writes expected 2", obs_wr.size());
        else begin
            passed++;
            total++;
            if (obs_wr[0] !== {9'd10, 12'h4AA} || obs_wr[1] !== {9'd12, 12'h5BB})
                $display("FAIL overrun_writes: got %h,%h expected %h,%h", obs_wr[0], obs_wr[1],
                         {9'd10, 12'h4AA}, {9'd12, 12'h5BB});
            else passed++;
        end
        total++;
        if (overrun_out !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun_out);
        else passed++;
    endtask

    task automatic test_stop_mid_flush();
        int fall;
        clear_logs();
        bpm_in = 8'd120;
        wr_ready_in = 1'b1;
        detected_note_in = {12'h5E5, 12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
        start_pulse();
        total++;
        if (overrun_out !== 1'b0) $display("FAIL overrun_clear_on_start: got %b expected 0", overrun_out);
        else passed++;
        repeat (12) cyc1();
        stop_in = 1'b1;
        cyc1();
        stop_in = 1'b0;
        cyc1();
        detected_note_in = {5{12'h0FF}};
        fall = -1;
        for (int i = 0; i < 100 && fall < 0; i++) begin
            cyc1();
            if (busy_out === 1'b0) fall = cyc;
        end
        total++;
        if (fall < 0) $display("FAIL stop_busy_timeout: busy_out still %b, expected 0", busy_out);
        else if (fall != last_wr_cyc + 1)
            $display("FAIL stop_busy_fall: busy fell at cyc %0d expected %0d", fall, last_wr_cyc + 1);
        else passed++;
        repeat (30) cyc1();
        total++;
        if (obs_ticks != 1) $display("FAIL stop_ticks: got %0d ticks expected 1", obs_ticks);
        else passed++;
        compare_writes("stop_wr");
    endtask

    task automatic test_async_reset();
        clear_logs();
        bpm_in = 8'd120;
        wr_ready_in = 1'b0;
        detected_note_in = {12'h5E5, 12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
        start_pulse();
        repeat (14) cyc1();
        total++;
        if (wr_valid_out !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", wr_valid_out);
        else passed++;
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        wr_ready_in = 1'b1;
        repeat (3) cyc1();
        check_reset_outputs("reset_held");
        total++;
        if (obs_wr.size() != 0) $display("FAIL reset_writes: got %0d writes expected 0", obs_wr.size());
        else passed++;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (5) cyc1();
        check_reset_outputs("post_reset_idle");
    endtask

    initial begin
        test_reset();
        test_tempo();
        test_two_writes();
        test_random();
        test_overrun();
        test_stop_mid_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
